// File: rtl/mips_run_monitor.sv
// rtl/mips_run_monitor.sv - run controller and trace monitor for the single-cycle MIPS core
// Sequences core reset, counts RUN cycles, detects PC self-loop halt or timeout, signs writebacks, buffers a trace.
module mips_run_monitor #(
  parameter int TRACE_DEPTH = 16,
  parameter int RST_CYCLES  = 2,
  parameter int TIMEOUT     = 40,
  parameter int HALT_REPEAT = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [31:0]                  pc_in,
  input  logic [31:0]                  ins_in,
  input  logic [31:0]                  alu_in,
  input  logic [4:0]                   wreg_in,
  input  logic                         wr_en,
  output logic                         cpu_reset,
  output logic                         busy,
  output logic                         done,
  output logic                         timeout,
  output logic [15:0]                  cycles,
  output logic [31:0]                  sig,
  input  logic                         trace_rd_en,
  output logic [63:0]                  trace_rd_data,
  output logic                         trace_rd_valid,
  output logic [$clog2(TRACE_DEPTH):0] trace_count,
  output logic                         trace_empty,
  output logic                         trace_overflow
);

  localparam int AW = $clog2(TRACE_DEPTH);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int HW = $clog2(HALT_REPEAT + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RST  = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_TMO  = 3'd4;

  logic [2:0]    r_state;
  logic [RW-1:0] r_rst_cnt;
  logic [15:0]   r_cycles;
  logic [31:0]   r_sig;
  logic [31:0]   r_prev_pc;
  logic [HW-1:0] r_halt_cnt;
  logic          r_first;
  logic [63:0]   r_mem [TRACE_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;
  logic [63:0]   r_rd_data;
  logic          r_rd_valid;

  logic          w_run;
  logic          w_launch;
  logic          w_same_pc;
  logic [HW-1:0] w_halt_next;
  logic          w_halt;
  logic [15:0]   w_cycles_next;
  logic          w_tmo;
  logic          w_full;
  logic          w_pop;
  logic          w_push;

  assign w_run         = (r_state == S_RUN);
  assign w_launch      = start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_TMO));
  // The first RUN cycle has no previous PC to compare against.
  assign w_same_pc     = !r_first && (pc_in == r_prev_pc);
  assign w_halt_next   = w_same_pc ? r_halt_cnt + 1'b1 : '0;
  assign w_halt        = w_run && (w_halt_next == HW'(HALT_REPEAT));
  assign w_cycles_next = r_cycles + 16'd1;
  assign w_tmo         = w_run && (w_cycles_next == 16'(TIMEOUT));
  assign w_full        = (r_count == (AW+1)'(TRACE_DEPTH));
  assign w_pop         = trace_rd_en && (r_count != '0) && !w_launch;
  assign w_push        = w_run && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_rst_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_TMO: begin
          if (start) begin
            r_state   <= S_RST;
            r_rst_cnt <= '0;
          end
        end
        S_RST: begin
          if (r_rst_cnt == RW'(RST_CYCLES - 1)) r_state <= S_RUN;
          else r_rst_cnt <= r_rst_cnt + 1'b1;
        end
        S_RUN: begin
          // Halt takes priority when it lands on the final allowed cycle.
          if (w_halt) r_state <= S_DONE;
          else if (w_tmo) r_state <= S_TMO;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cycles   <= '0;
      r_sig      <= '0;
      r_prev_pc  <= '0;
      r_halt_cnt <= '0;
      r_first    <= 1'b1;
    end else if (w_launch) begin
      r_cycles   <= '0;
      r_sig      <= '0;
      r_halt_cnt <= '0;
      r_first    <= 1'b1;
    end else if (w_run) begin
      r_cycles <= w_cycles_next;
      if (wr_en && (wreg_in != 5'd0)) r_sig <= {r_sig[30:0], r_sig[31]} ^ alu_in;
      r_halt_cnt <= w_halt_next;
      r_prev_pc  <= pc_in;
      r_first    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else if (w_launch) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_pop;
      if (w_pop) begin
        r_rd_data <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + 1'b1;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_run && w_full && !w_pop) r_overflow <= 1'b1;
      if (w_push && !w_pop) r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {pc_in, ins_in};
  end

  assign cpu_reset      = !w_run;
  assign busy           = (r_state == S_RST) || w_run;
  assign done           = (r_state == S_DONE);
  assign timeout        = (r_state == S_TMO);
  assign cycles         = r_cycles;
  assign sig            = r_sig;
  assign trace_rd_data  = r_rd_data;
  assign trace_rd_valid = r_rd_valid;
  assign trace_count    = r_count;
  assign trace_empty    = (r_count == '0);
  assign trace_overflow = r_overflow;

endmodule

// File: tb/tb_mips_run_monitor.sv
// tb/tb_mips_run_monitor.sv - self-checking bench for mips_run_monitor
// Directed table, hand sequences for halt/timeout/FIFO corners, then random traffic against a queue-based model.
module tb_mips_run_monitor;

  localparam int DEPTH = 16;
  localparam int RSTC  = 2;
  localparam int TMO   = 40;
  localparam int HREP  = 3;

  logic        clk = 1'b0;
  logic        reset, start, wr_en, trace_rd_en;
  logic [31:0] pc_in, ins_in, alu_in;
  logic [4:0]  wreg_in;
  logic        cpu_reset, busy, done, timeout;
  logic [15:0] cycles;
  logic [31:0] sig;
  logic [63:0] trace_rd_data;
  logic        trace_rd_valid;
  logic [4:0]  trace_count;
  logic        trace_empty, trace_overflow;

  mips_run_monitor #(
    .TRACE_DEPTH(DEPTH), .RST_CYCLES(RSTC), .TIMEOUT(TMO), .HALT_REPEAT(HREP)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pc_in(pc_in), .ins_in(ins_in),
    .alu_in(alu_in), .wreg_in(wreg_in), .wr_en(wr_en), .cpu_reset(cpu_reset),
    .busy(busy), .done(done), .timeout(timeout), .cycles(cycles), .sig(sig),
    .trace_rd_en(trace_rd_en), .trace_rd_data(trace_rd_data),
    .trace_rd_valid(trace_rd_valid), .trace_count(trace_count),
    .trace_empty(trace_empty), .trace_overflow(trace_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ins_of(input logic [31:0] pc);
    return pc ^ 32'h8C21_5A00;
  endfunction

  task automatic quiet_inputs();
    start = 1'b0; wr_en = 1'b0; trace_rd_en = 1'b0;
    wreg_in = 5'd0; alu_in = 32'd0; pc_in = 32'd0; ins_in = 32'd0;
  endtask

  task automatic do_reset();
    quiet_inputs();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic launch();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (RSTC) tick();
  endtask

  typedef struct {
    logic        rst_n;
    logic        start;
    logic        wr_en;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [4:0]  wreg;
    logic        e_cpu_reset;
    logic        e_busy;
    logic        e_done;
    logic [15:0] e_cycles;
    logic [31:0] e_sig;
    logic [4:0]  e_count;
  } vec_t;

  vec_t vecs[12];

  // Behavioural reference: phase, PC history and a queue stand in for the trace.
  int          m_phase;
  int          m_rst_left;
  logic [15:0] m_cycles;
  logic [31:0] m_sig;
  logic [31:0] m_pcs[$];
  logic [63:0] m_fifo[$];
  logic        m_ovf, m_rd_valid;
  logic [63:0] m_rd_data;

  task automatic model_reset();
    m_phase = 0; m_rst_left = 0; m_cycles = 0; m_sig = 0;
    m_pcs.delete(); m_fifo.delete();
    m_ovf = 0; m_rd_valid = 0; m_rd_data = 0;
  endtask

  task automatic model_step();
    bit launch_now, popped;
    int size_before, reps;
    if (!reset) begin
      model_reset();
      return;
    end
    launch_now  = start && (m_phase == 0 || m_phase == 3 || m_phase == 4);
    size_before = m_fifo.size();
    popped      = 0;
    if (launch_now) m_rd_valid = 0;
    else if (trace_rd_en && size_before > 0) begin
      m_rd_data  = m_fifo.pop_front();
      m_rd_valid = 1;
      popped     = 1;
    end else m_rd_valid = 0;
    case (m_phase)
      1: begin
        m_rst_left--;
        if (m_rst_left == 0) m_phase = 2;
      end
      2: begin
        m_cycles++;
        if (size_before == DEPTH && !popped) m_ovf = 1;
        else m_fifo.push_back({pc_in, ins_in});
        if (wr_en && wreg_in != 0) m_sig = ((m_sig << 1) | (m_sig >> 31)) ^ alu_in;
        m_pcs.push_back(pc_in);
        reps = 0;
        for (int j = m_pcs.size() - 1; j > 0 && m_pcs[j] == m_pcs[j-1]; j--) reps++;
        if (reps >= HREP) m_phase = 3;
        else if (m_cycles == TMO) m_phase = 4;
      end
      default: begin
        if (launch_now) begin
          m_phase = 1; m_rst_left = RSTC; m_cycles = 0; m_sig = 0;
          m_pcs.delete(); m_fifo.delete(); m_ovf = 0;
        end
      end
    endcase
  endtask

  task automatic model_compare(input int cyc);
    string p;
    p = $sformatf("rnd%0d_", cyc);
    chk({p, "cpu_reset"}, cpu_reset, m_phase != 2);
    chk({p, "busy"}, busy, m_phase == 1 || m_phase == 2);
    chk({p, "done"}, done, m_phase == 3);
    chk({p, "timeout"}, timeout, m_phase == 4);
    chk({p, "cycles"}, cycles, m_cycles);
    chk({p, "sig"}, sig, m_sig);
    chk({p, "rd_valid"}, trace_rd_valid, m_rd_valid);
    chk({p, "rd_data"}, trace_rd_data, m_rd_data);
    chk({p, "count"}, trace_count, m_fifo.size());
    chk({p, "empty"}, trace_empty, m_fifo.size() == 0);
    chk({p, "overflow"}, trace_overflow, m_ovf);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] pcs[7];
    logic [31:0] rpc;
    int n;

    quiet_inputs();
    reset = 1'b0;

    vecs[0]  = '{0, 0, 0, 0,  0,           0,  1, 0, 0, 0, 0,           0};
    vecs[1]  = '{0, 0, 0, 0,  0,           0,  1, 0, 0, 0, 0,           0};
    vecs[2]  = '{1, 1, 0, 0,  0,           0,  1, 1, 0, 0, 0,           0};
    vecs[3]  = '{1, 0, 0, 0,  0,           0,  1, 1, 0, 0, 0,           0};
    vecs[4]  = '{1, 0, 0, 0,  0,           0,  0, 1, 0, 0, 0,           0};
    vecs[5]  = '{1, 0, 1, 0,  1,           1,  0, 1, 0, 1, 1,           1};
    vecs[6]  = '{1, 0, 1, 4,  2,           2,  0, 1, 0, 2, 0,           2};
    vecs[7]  = '{1, 0, 1, 8,  'hFFFF,      0,  0, 1, 0, 3, 0,           3};
    vecs[8]  = '{1, 0, 1, 12, 'hA5A50000,  5,  0, 1, 0, 4, 'hA5A50000,  4};
    vecs[9]  = '{1, 0, 0, 16, 'hFFFFFFFF,  5,  0, 1, 0, 5, 'hA5A50000,  5};
    vecs[10] = '{1, 0, 1, 20, 1,           31, 0, 1, 0, 6, 'h4B4A0000,  6};
    vecs[11] = '{0, 0, 0, 24, 0,           0,  1, 0, 0, 0, 0,           0};

    for (int i = 0; i < 12; i++) begin
      reset   = vecs[i].rst_n;
      start   = vecs[i].start;
      wr_en   = vecs[i].wr_en;
      pc_in   = vecs[i].pc;
      ins_in  = ins_of(vecs[i].pc);
      alu_in  = vecs[i].alu;
      wreg_in = vecs[i].wreg;
      tick();
      chk($sformatf("vec%0d_cpu_reset", i), cpu_reset, vecs[i].e_cpu_reset);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
      chk($sformatf("vec%0d_done", i), done, vecs[i].e_done);
      chk($sformatf("vec%0d_timeout", i), timeout, 1'b0);
      chk($sformatf("vec%0d_cycles", i), cycles, vecs[i].e_cycles);
      chk($sformatf("vec%0d_sig", i), sig, vecs[i].e_sig);
      chk($sformatf("vec%0d_count", i), trace_count, vecs[i].e_count);
    end
    chk("midrun_reset_empty", trace_empty, 1'b1);
    chk("midrun_reset_rd_valid", trace_rd_valid, 1'b0);

    // Halt: PC walks 0,4,8,12 then sticks at 12.
    do_reset();
    launch();
    chk("halt_run_cpu_reset", cpu_reset, 1'b0);
    pcs = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd12, 32'd12, 32'd12};
    for (int i = 0; i < 7; i++) begin
      pc_in  = pcs[i];
      ins_in = ins_of(pcs[i]);
      tick();
    end
    chk("halt_done", done, 1'b1);
    chk("halt_cycles", cycles, 16'd7);
    chk("halt_count", trace_count, 5'd7);
    chk("halt_cpu_reset", cpu_reset, 1'b1);
    chk("halt_busy", busy, 1'b0);
    trace_rd_en = 1'b1;
    tick();
    trace_rd_en = 1'b0;
    chk("halt_pop0_valid", trace_rd_valid, 1'b1);
    chk("halt_pop0_data", trace_rd_data, {32'd0, ins_of(32'd0)});
    tick();
    chk("halt_pop_pulse", trace_rd_valid, 1'b0);
    chk("halt_count_after_pop", trace_count, 5'd6);
    trace_rd_en = 1'b1;
    for (int k = 1; k < 7; k++) begin
      tick();
      chk($sformatf("halt_pop%0d_data", k), trace_rd_data, {pcs[k], ins_of(pcs[k])});
    end
    tick();
    chk("pop_empty_valid", trace_rd_valid, 1'b0);
    chk("pop_empty_count", trace_count, 5'd0);
    chk("pop_empty_flag", trace_empty, 1'b1);
    chk("done_holds", done, 1'b1);
    trace_rd_en = 1'b0;

    // Timeout: PC never repeats, no pops.
    do_reset();
    launch();
    n = 0;
    while (!timeout && n < 100) begin
      pc_in  = 32'(4 * n);
      ins_in = ins_of(pc_in);
      tick();
      n++;
    end
    chk("tmo_run_cycles", n, TMO);
    chk("tmo_flag", timeout, 1'b1);
    chk("tmo_done", done, 1'b0);
    chk("tmo_cycles", cycles, 16'(TMO));
    chk("tmo_count", trace_count, 5'd16);
    chk("tmo_overflow", trace_overflow, 1'b1);
    chk("tmo_cpu_reset", cpu_reset, 1'b1);

    // Full FIFO with a pop every cycle keeps accepting pushes.
    do_reset();
    launch();
    for (int k = 0; k < 16; k++) begin
      pc_in  = 32'(4 * k);
      ins_in = ins_of(pc_in);
      tick();
    end
    chk("full_count", trace_count, 5'd16);
    chk("full_overflow", trace_overflow, 1'b0);
    trace_rd_en = 1'b1;
    for (int k = 16; k < 36; k++) begin
      pc_in  = 32'(4 * k);
      ins_in = ins_of(pc_in);
      tick();
      chk($sformatf("fullpop%0d_count", k), trace_count, 5'd16);
      chk($sformatf("fullpop%0d_data", k), trace_rd_data, {32'(4 * (k - 16)), ins_of(32'(4 * (k - 16)))});
    end
    trace_rd_en = 1'b0;
    chk("fullpop_overflow", trace_overflow, 1'b0);

    // Halt landing on the final timeout cycle resolves to DONE.
    do_reset();
    launch();
    for (int k = 1; k <= TMO; k++) begin
      pc_in  = (k <= 37) ? 32'(4 * (k - 1)) : 32'd144;
      ins_in = ins_of(pc_in);
      tick();
      if (k == 39) chk("coincide_not_early", done, 1'b0);
    end
    chk("coincide_done", done, 1'b1);
    chk("coincide_timeout", timeout, 1'b0);
    chk("coincide_cycles", cycles, 16'(TMO));

    // Random traffic against the reference model.
    do_reset();
    model_reset();
    rpc = 32'd0;
    for (int c = 0; c < 3000; c++) begin
      reset       = ($urandom_range(0, 299) != 0);
      start       = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) != 0) rpc = rpc + 32'd4;
      pc_in       = rpc;
      ins_in      = $urandom;
      alu_in      = $urandom;
      wreg_in     = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      wr_en       = $urandom_range(0, 1) == 1;
      trace_rd_en = ($urandom_range(0, 3) == 0);
      model_step();
      tick();
      model_compare(c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
